// File: rtl/ps2_host_tx_if.sv
// Command-side handshake between a PS/2 host controller and its client logic.
interface ps2_host_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (output tx_start, tx_data, input busy, done, err, err_code);
    modport slave  (input tx_start, tx_data, output busy, done, err, err_code);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out
// frame driven by the device clock, acknowledge check and bus-idle wait.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int FIRST_TIMEOUT  = 750000,
    parameter int FRAME_TIMEOUT  = 100000,
    parameter int ACK_TIMEOUT    = 100000
) (
    input  logic            iCLK_50,
    input  logic            reset,
    ps2_host_tx_if.slave    cmd,
    input  logic            ps2_clk_in,
    input  logic            ps2_dat_in,
    output logic            ps2_clk_oe,
    output logic            ps2_dat_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] RTS_LAST     = 20'(RTS_CYCLES - 1);
    localparam logic [19:0] FIRST_LAST   = 20'(FIRST_TIMEOUT - 1);
    localparam logic [19:0] FRAME_LAST   = 20'(FRAME_TIMEOUT - 1);
    localparam logic [19:0] ACK_LAST     = 20'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [19:0] timer;
    logic [8:0]  frame;
    logic        busy_q, done_q, err_q;
    logic [1:0]  err_code_q;

    logic clk_s1, clk_s2, clk_d;
    logic dat_s1, dat_s2;
    logic fe;
    logic fail;
    logic [1:0] fail_code;

    assign cmd.busy     = busy_q;
    assign cmd.done     = done_q;
    assign cmd.err      = err_q;
    assign cmd.err_code = err_code_q;

    // Synchronizers come out of reset at 1 so an idle bus never looks like an edge.
    always_ff @(posedge iCLK_50) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
        end
    end

    assign fe = clk_d & ~clk_s2;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        fail      = 1'b0;
        fail_code = 2'b00;
        case (state)
            SEND: begin
                if (fe) begin
                    if (bit_cnt == 4'd10 && dat_s2) begin
                        fail      = 1'b1;
                        fail_code = 2'b11;
                    end
                end else if (bit_cnt == 4'd0) begin
                    if (timer == FIRST_LAST) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end
                end else if (timer == FRAME_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            WAIT_IDLE: begin
                if (!(clk_s2 && dat_s2) && timer == ACK_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the command shadow is a pure datapath register written before every use, so it carries no reset.
    always_ff @(posedge iCLK_50) begin
        if (state == IDLE && cmd.tx_start)
            frame <= {~^cmd.tx_data, cmd.tx_data};
    end

    always_ff @(posedge iCLK_50) begin
        // NOTE: sequential state uses <= only, so every register sees pre-edge values.
        if (reset) begin
            state      <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            bit_cnt    <= 4'd0;
            timer      <= 20'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            timer  <= timer + 20'd1;
            if (fail) begin
                state      <= IDLE;
                busy_q     <= 1'b0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= fail_code;
                timer      <= 20'd0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= 20'd0;
                        if (cmd.tx_start) begin
                            state      <= INHIBIT;
                            busy_q     <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            ps2_dat_oe <= 1'b0;
                            err_code_q <= 2'b00;
                            bit_cnt    <= 4'd0;
                        end
                    end
                    INHIBIT: begin
                        if (timer == INHIBIT_LAST) begin
                            state      <= RTS;
                            ps2_dat_oe <= 1'b1;
                            timer      <= 20'd0;
                        end
                    end
                    RTS: begin
                        if (timer == RTS_LAST) begin
                            state      <= SEND;
                            ps2_clk_oe <= 1'b0;
                            timer      <= 20'd0;
                        end
                    end
                    SEND: begin
                        if (fe) begin
                            if (bit_cnt != 4'd11)
                                bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd0)
                                timer <= 20'd1;
                            // Edges 1..9 shift out data LSB first, then parity.
                            if (bit_cnt < 4'd9)
                                ps2_dat_oe <= ~frame[bit_cnt];
                            else if (bit_cnt == 4'd9)
                                ps2_dat_oe <= 1'b0;
                            else begin
                                state <= WAIT_IDLE;
                                timer <= 20'd0;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_s2 && dat_s2) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: wired-AND bus with a behavioural PS/2 device.
module tb_ps2_host_tx;
    localparam int INH   = 40;
    localparam int RTS   = 12;
    localparam int FIRST = 600;
    localparam int FRAME = 1200;
    localparam int ACK   = 300;

    logic iCLK_50 = 1'b0;
    logic reset   = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk_oe, ps2_dat_oe;
    logic ps2_clk_in, ps2_dat_in;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, busy_cyc = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    logic obs [1:11];

    always #5 iCLK_50 = ~iCLK_50;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx_if cmd ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .FIRST_TIMEOUT (FIRST),
        .FRAME_TIMEOUT (FRAME),
        .ACK_TIMEOUT   (ACK)
    ) dut (
        .iCLK_50   (iCLK_50),
        .reset     (reset),
        .cmd       (cmd),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always @(posedge iCLK_50) cyc <= cyc + 1;

    always @(negedge iCLK_50) begin
        if (cmd.done) done_cnt++;
        if (cmd.err) err_cnt++;
        if (cmd.done && cmd.err) both_cnt++;
        if ((cmd.done && done_prev) || (cmd.err && err_prev)) long_cnt++;
        if (cmd.busy) busy_cyc++;
        done_prev = cmd.done;
        err_prev  = cmd.err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    // Expected host drive after falling edge k: inverted data LSB first,
    // inverted odd parity, then a released line for the stop bit.
    function automatic logic exp_dat_oe(input logic [7:0] d, input int k);
        logic par;
        par = ($countones(d) % 2 == 0);
        if (k <= 8) return !d[k-1];
        if (k == 9) return !par;
        return 1'b0;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge iCLK_50);
        cmd.tx_start = 1'b1;
        cmd.tx_data  = d;
        @(negedge iCLK_50);
        cmd.tx_start = 1'b0;
        cmd.tx_data  = 8'($urandom);
    endtask

    task automatic wait_send(output int inh, output int rts);
        inh = 0;
        rts = 0;
        while (ps2_clk_oe && !ps2_dat_oe && inh < 4 * INH) begin
            inh++;
            @(negedge iCLK_50);
        end
        while (ps2_clk_oe && ps2_dat_oe && rts < 4 * RTS) begin
            rts++;
            @(negedge iCLK_50);
        end
    endtask

    task automatic device(input int n_edges, input bit ack, input int half, output int t_first);
        t_first = 0;
        for (int e = 1; e <= n_edges; e++) begin
            repeat (half) @(negedge iCLK_50);
            if (e == 11) dev_dat = !ack;
            repeat (half) @(negedge iCLK_50);
            dev_clk = 1'b0;
            if (e == 1) t_first = cyc;
            repeat (half) @(negedge iCLK_50);
            obs[e]  = ps2_dat_oe;
            dev_clk = 1'b1;
        end
        repeat (half) @(negedge iCLK_50);
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (cmd.busy && waited < 3000) begin
            @(negedge iCLK_50);
            waited++;
        end
        repeat (3) @(negedge iCLK_50);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iCLK_50);
        n_total++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        n_total++; if (ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
        n_total++; if (cmd.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", cmd.busy); end
        n_total++; if (cmd.done !== 1'b0 || cmd.err !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", cmd.done, cmd.err); end
        n_total++; if (cmd.err_code !== 2'b00) begin n_bad++; $display("FAIL reset_err_code: got %b want 00", cmd.err_code); end
        reset = 1'b0;
        repeat (3) @(negedge iCLK_50);
    endtask

    task automatic test_basic_frame(input logic [7:0] d, input int half);
        int inh, rts, tf, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        wait_send(inh, rts);
        n_total++; if (inh !== INH) begin n_bad++; $display("FAIL inhibit_len %h: got %0d want %0d", d, inh, INH); end
        n_total++; if (rts !== RTS) begin n_bad++; $display("FAIL rts_len %h: got %0d want %0d", d, rts, RTS); end
        n_total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin n_bad++; $display("FAIL start_bit %h: got clk_oe=%b dat_oe=%b want 0 1", d, ps2_clk_oe, ps2_dat_oe); end
        device(11, 1'b1, half, tf);
        wait_idle();
        for (int k = 1; k <= 10; k++) begin
            n_total++;
            if (obs[k] !== exp_dat_oe(d, k)) begin n_bad++; $display("FAIL frame_bit %h fe%0d: got %b want %b", d, k, obs[k], exp_dat_oe(d, k)); end
        end
        n_total++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL frame_done %h: got %0d pulses want 1", d, done_cnt - d0); end
        n_total++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL frame_err %h: got %0d pulses want 0", d, err_cnt - e0); end
        n_total++; if (cmd.busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || cmd.err_code !== 2'b00) begin
            n_bad++; $display("FAIL frame_end %h: got busy=%b clk_oe=%b dat_oe=%b code=%b want 0 0 0 00", d, cmd.busy, ps2_clk_oe, ps2_dat_oe, cmd.err_code);
        end
    endtask

    task automatic test_idle_fe();
        int b0, d0, e0, tf;
        b0 = busy_cyc; d0 = done_cnt; e0 = err_cnt;
        device(4, 1'b1, 10, tf);
        repeat (3) @(negedge iCLK_50);
        n_total++; if (busy_cyc - b0 !== 0) begin n_bad++; $display("FAIL idle_fe_busy: got %0d busy cycles want 0", busy_cyc - b0); end
        n_total++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL idle_fe_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_first_timeout();
        int inh, rts, k, d0;
        d0 = done_cnt;
        start_tx(8'($urandom));
        wait_send(inh, rts);
        k = 0;
        while (!cmd.err && k < FIRST + 50) begin
            @(negedge iCLK_50);
            k++;
        end
        n_total++; if (k !== FIRST) begin n_bad++; $display("FAIL first_timeout_time: got %0d want %0d", k, FIRST); end
        n_total++; if (cmd.err_code !== 2'b01) begin n_bad++; $display("FAIL first_timeout_code: got %b want 01", cmd.err_code); end
        n_total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL first_timeout_release: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
        repeat (3) @(negedge iCLK_50);
        n_total++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL first_timeout_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_frame_timeout();
        int inh, rts, tf, k, t_err, d0;
        d0 = done_cnt;
        start_tx(8'($urandom));
        wait_send(inh, rts);
        device(4, 1'b1, $urandom_range(8, 16), tf);
        k = 0;
        while (!cmd.err && k < FRAME + 100) begin
            @(negedge iCLK_50);
            k++;
        end
        t_err = cyc;
        // fe strobe trails the device's falling edge by the two synchronizer stages.
        n_total++; if (t_err - tf !== FRAME + 2) begin n_bad++; $display("FAIL frame_timeout_time: got %0d want %0d", t_err - tf, FRAME + 2); end
        n_total++; if (cmd.err_code !== 2'b10) begin n_bad++; $display("FAIL frame_timeout_code: got %b want 10", cmd.err_code); end
        n_total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL frame_timeout_release: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
        repeat (3) @(negedge iCLK_50);
        n_total++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL frame_timeout_done: got %0d want 0", done_cnt - d0); end
    endtask

    task automatic test_nack();
        int inh, rts, tf, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'($urandom));
        wait_send(inh, rts);
        device(11, 1'b0, 10, tf);
        wait_idle();
        n_total++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL nack_err: got %0d pulses want 1", err_cnt - e0); end
        n_total++; if (cmd.err_code !== 2'b11) begin n_bad++; $display("FAIL nack_code: got %b want 11", cmd.err_code); end
        n_total++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL nack_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int inh, rts, tf, d0, e0, half;
        logic [7:0] d1;
        d1 = 8'($urandom);
        half = 10;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(d1);
        wait_send(inh, rts);
        fork
            device(11, 1'b1, half, tf);
            begin
                repeat (6 * half) @(negedge iCLK_50);
                start_tx(~d1);
            end
        join
        wait_idle();
        for (int k = 1; k <= 9; k++) begin
            n_total++;
            if (obs[k] !== exp_dat_oe(d1, k)) begin n_bad++; $display("FAIL b2b_bit fe%0d: got %b want %b", k, obs[k], exp_dat_oe(d1, k)); end
        end
        n_total++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL b2b_pulses: got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0); end
        n_total++; if (cmd.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b want 0", cmd.busy); end
    endtask

    task automatic test_reset_mid();
        int inh, rts, tf, d0, e0;
        logic [7:0] d;
        d = 8'($urandom) & 8'hEF;
        start_tx(d);
        wait_send(inh, rts);
        device(5, 1'b1, 10, tf);
        n_total++; if (cmd.busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin n_bad++; $display("FAIL mid_pre_reset: got busy=%b dat_oe=%b want 1 1", cmd.busy, ps2_dat_oe); end
        repeat (2) @(negedge iCLK_50);
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b1;
        @(negedge iCLK_50);
        reset = 1'b0;
        n_total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || cmd.busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_release: got clk_oe=%b dat_oe=%b busy=%b want 0 0 0", ps2_clk_oe, ps2_dat_oe, cmd.busy);
        end
        repeat (30) @(negedge iCLK_50);
        n_total++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin n_bad++; $display("FAIL mid_reset_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_pulse_shape();
        n_total++; if (both_cnt !== 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d cycles want 0", both_cnt); end
        n_total++; if (long_cnt !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d stretched cycles want 0", long_cnt); end
    endtask

    initial begin
        cmd.tx_start = 1'b0;
        cmd.tx_data  = 8'h00;
        test_reset();
        test_basic_frame(8'hED, 12);
        test_basic_frame(8'h00, 10);
        repeat (4) test_basic_frame(8'($urandom), int'($urandom_range(8, 16)));
        test_idle_fe();
        test_first_timeout();
        test_frame_timeout();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        test_basic_frame(8'($urandom), 9);
        test_pulse_shape();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000; clock held low before request-to-send (100 us at 50 MHz).
REQ-002 Parameter RTS_CYCLES, default 50; data-low/clock-low overlap before clock release.
REQ-003 Parameter FIRST_TIMEOUT, default 750000; maximum cycles from clock release to the first device falling edge.
REQ-004 Parameter FRAME_TIMEOUT, default 100000; maximum cycles from the first falling edge to the 11th falling edge.
REQ-005 Parameter ACK_TIMEOUT, default 100000; maximum cycles spent in WAIT_IDLE.
REQ-006 Port iCLK_50, input, 1; single clock for all logic.
REQ-007 Port reset, input, 1; synchronous, active-high reset.
REQ-008 Port tx_start, input, 1; one-cycle request to send tx_data.
REQ-009 Port tx_data, input, 8; command byte, sampled when tx_start is accepted.
REQ-010 Port ps2_clk_in, input, 1; raw PS/2 clock line level, asynchronous.
REQ-011 Port ps2_dat_in, input, 1; raw PS/2 data line level, asynchronous.
REQ-012 Port ps2_clk_oe, output, 1; 1 drives the clock line low, 0 releases it.
REQ-013 Port ps2_dat_oe, output, 1; 1 drives the data line low, 0 releases it.
REQ-014 Port busy, output, 1; high in every state except IDLE, so the receiver can ignore host-driven traffic.
REQ-015 Port done, output, 1; one-cycle pulse when a frame is acknowledged.
REQ-016 Port err, output, 1; one-cycle pulse when a frame fails.
REQ-017 Port err_code, output, 2; failure cause, held until the next accepted tx_start.

Function
REQ-018 ps2_clk_in and ps2_dat_in SHALL each pass through a 2-flop synchronizer.
REQ-019 A falling edge (fe) SHALL be a 1-cycle strobe when the synchronized clock is 1 in the previous cycle and 0 in the current cycle.
REQ-020 tx_start SHALL be accepted only in IDLE; when accepted, tx_data is latched, odd parity is computed (parity = ~^tx_data), err_code clears to 00, and the state goes to INHIBIT.
REQ-021 tx_start asserted while busy=1 SHALL be ignored without side effects.
REQ-022 INHIBIT: clk_oe=1 and dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
REQ-023 RTS: clk_oe=1 and dat_oe=1 (start bit) for exactly RTS_CYCLES cycles, then go to SEND.
REQ-024 SEND: clk_oe=0 throughout; dat_oe stays 1 until the first fe.
REQ-025 SEND output by falling edge, applied the cycle after each fe strobe:
  - fe 1 to 8: dat_oe = ~tx_data[n-1], LSB first;
  - fe 9: dat_oe = ~parity;
  - fe 10: dat_oe = 0 (stop bit, line released).
REQ-026 fe 11: sample the synchronized data line in the fe cycle; 0 means ack, 1 means err_code=11. An ack goes to WAIT_IDLE.
REQ-027 SEND timeouts:
  - no fe within FIRST_TIMEOUT cycles of entering SEND gives err_code=01;
  - fe 11 not reached within FRAME_TIMEOUT cycles of fe 1 gives err_code=10.
REQ-028 WAIT_IDLE: wait until both synchronized lines are 1, then pulse done and go to IDLE; exceeding ACK_TIMEOUT gives err_code=11.
REQ-029 Any error SHALL release both lines (clk_oe=0, dat_oe=0) in the cycle err pulses, then return to IDLE.
REQ-030 done and err SHALL never assert in the same cycle, and each SHALL pulse for exactly one cycle per frame.
REQ-031 The state set SHALL be IDLE, INHIBIT, RTS, SEND, WAIT_IDLE; the bit counter is 4 bits (0 to 11) and saturates.
REQ-032 The timeout counter SHALL be 20 bits and reload on every state entry; the RTS_CYCLES and INHIBIT_CYCLES counters reload on entry to their states.
REQ-033 A device-initiated falling edge in IDLE SHALL be ignored.
REQ-034 A falling edge during INHIBIT or RTS SHALL be ignored and SHALL NOT advance the bit counter.

Reset
REQ-035 When reset=1 on a clock edge, these SHALL all be 0 on the next cycle: state (IDLE), ps2_clk_oe, ps2_dat_oe, busy, done, err, err_code, bit counter, timeout counter.
REQ-036 Reset mid-frame SHALL release both lines on the next cycle, and SHALL produce no done or err pulse.
REQ-037 The synchronizer flops SHALL reset to 1, which represents an idle bus.

Verification
REQ-038 tx_start with tx_data=0xED (parity 1), device model clocking at 12.5 kHz and acking:
  - clk_oe=1 for 5000 cycles, then dat_oe=1 and clk_oe=1 for 50 cycles;
  - after fe 1 to 8, dat_oe = 0,1,0,0,1,0,0,0;
  - after fe 9, dat_oe=0 (parity); after fe 10, dat_oe=0 (stop);
  - ack accepted, then done=1 for 1 cycle with err=0.
REQ-039 tx_data=0x00 (parity 1): after fe 1 to 8, dat_oe=1; after fe 9, dat_oe=0; the frame ends with done.
REQ-040 Device never clocks: err=1 exactly FIRST_TIMEOUT cycles after entering SEND, err_code=01, both oe=0.
REQ-041 Device stops after 4 edges: err_code=10 at FRAME_TIMEOUT after fe 1.
REQ-042 Device leaves data high at fe 11: err_code=11, done never asserts.
REQ-043 Two further cases:
  - a second tx_start during SEND is ignored, and exactly one done is observed;
  - reset asserted after fe 5 gives clk_oe=0, dat_oe=0, busy=0 on the next cycle, with no err pulse.
